boot_loader: RTL and testbench

Upstream program loader for the 16-bit CPU and its 128-word Memory. After reset it holds the CPU stopped and accepts a byte stream containing a length header, program words and an XOR checksum. It writes each assembled word into Memory through the same write port the CPU uses. When the checksum matches it releases the CPU with `cpu_run`; on any error it locks up until reset.

---
 rtl/boot_loader_if.sv | 28 ++
 rtl/boot_loader.sv | 154 +++++++++++++++
 tb/tb_boot_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
// The master side is the loader; the slave side is the stream source plus Memory.
interface boot_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_in;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_in
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_in
    );
endinterface

// File: rtl/boot_loader.sv
// Loads a length-prefixed, XOR-checksummed program into Memory, then releases the CPU.
// Writes land one cycle after each DATA_LO byte; in_ready drops for good once RUN or ERROR is reached.
module boot_loader #(
    parameter int WORDS = 128,
    parameter int IDX_W = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    boot_loader_if.master bus,
    output logic          cpu_run,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, RUN, ERROR
    } state_t;

    localparam logic [15:0] L_WORDS = 16'(WORDS);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cnt_hi, w_cnt_hi_nxt;
    logic [IDX_W:0]   r_n, w_n_nxt;
    logic [7:0]       r_hi, w_hi_nxt;
    logic [IDX_W:0]   r_idx, w_idx_nxt;
    logic [7:0]       r_xor, w_xor_nxt;
    logic             r_we, w_we_nxt;
    logic [15:0]      r_addr, w_addr_nxt;
    logic [15:0]      r_dat, w_dat_nxt;
    logic             r_run, w_run_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    logic             w_ready;
    logic             w_xfer;
    logic [15:0]      w_n_full;
    logic [IDX_W:0]   w_idx_inc;

    assign w_ready   = (r_state == CNT_HI) || (r_state == CNT_LO) || (r_state == DATA_HI) ||
                       (r_state == DATA_LO) || (r_state == CHECK);
    assign w_xfer    = bus.in_valid && w_ready;
    assign w_n_full  = {r_cnt_hi, bus.in_data};
    assign w_idx_inc = r_idx + {{IDX_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_hi_nxt = r_cnt_hi;
        w_n_nxt      = r_n;
        w_hi_nxt     = r_hi;
        w_idx_nxt    = r_idx;
        w_xor_nxt    = r_xor;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = r_addr;
        w_dat_nxt    = r_dat;
        w_run_nxt    = r_run;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;

        // The checksum byte itself is excluded from the running XOR.
        if (w_xfer && (r_state != CHECK)) begin
            w_xor_nxt = r_xor ^ bus.in_data;
        end

        case (r_state)
            CNT_HI: begin
                if (w_xfer) begin
                    w_cnt_hi_nxt = bus.in_data;
                    w_state_nxt  = CNT_LO;
                end
            end
            CNT_LO: begin
                if (w_xfer) begin
                    w_n_nxt   = w_n_full[IDX_W:0];
                    w_idx_nxt = '0;
                    if (w_n_full > L_WORDS) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ERROR;
                    end else if (w_n_full == 16'd0) begin
                        w_state_nxt = CHECK;
                    end else begin
                        w_state_nxt = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (w_xfer) begin
                    w_hi_nxt    = bus.in_data;
                    w_state_nxt = DATA_LO;
                end
            end
            DATA_LO: begin
                if (w_xfer) begin
                    w_dat_nxt   = {r_hi, bus.in_data};
                    w_addr_nxt  = {{(15 - IDX_W){1'b0}}, r_idx[IDX_W-1:0], 1'b0};
                    w_we_nxt    = 1'b1;
                    w_idx_nxt   = w_idx_inc;
                    w_state_nxt = (w_idx_inc == r_n) ? CHECK : DATA_HI;
                end
            end
            CHECK: begin
                if (w_xfer) begin
                    if (bus.in_data == r_xor) begin
                        w_run_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ERROR;
                    end
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= CNT_HI;
            r_cnt_hi <= '0;
            r_n      <= '0;
            r_hi     <= '0;
            r_idx    <= '0;
            r_xor    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_dat    <= '0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt_hi <= w_cnt_hi_nxt;
            r_n      <= w_n_nxt;
            r_hi     <= w_hi_nxt;
            r_idx    <= w_idx_nxt;
            r_xor    <= w_xor_nxt;
            r_we     <= w_we_nxt;
            r_addr   <= w_addr_nxt;
            r_dat    <= w_dat_nxt;
            r_run    <= w_run_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.mem_we   = r_we;
    assign bus.mem_addr = r_addr;
    assign bus.mem_in   = r_dat;
    assign cpu_run      = r_run;
    assign done         = r_done;
    assign error        = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of whole streams plus hand-written corner sequences.
module tb_boot_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_run, done, error;

    boot_loader_if bif ();

    boot_loader #(.WORDS(128), .IDX_W(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif),
        .cpu_run (cpu_run),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          wr_total = 0;
    int          overlap = 0;
    logic        prev_we = 1'b0;
    logic [15:0] wr_addr [0:1023];
    logic [15:0] wr_dat  [0:1023];
    logic [15:0] mem     [0:127];

    // Memory model and write log, sampled on the edge where Memory commits.
    always @(posedge clk) begin
        if (bif.mem_we) begin
            if (wr_total < 1024) begin
                wr_addr[wr_total] <= bif.mem_addr;
                wr_dat[wr_total]  <= bif.mem_in;
            end
            mem[bif.mem_addr[7:1]] <= bif.mem_in;
            wr_total <= wr_total + 1;
            if (prev_we) overlap <= overlap + 1;
        end
        prev_we <= bif.mem_we;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offer one byte for one cycle after 'gap' idle cycles; returns at #1 after its edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    typedef struct {
        string           name;
        int              len;
        logic [0:9][7:0] b;
        int              exp_wr;
        bit              exp_done;
        bit              exp_err;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] s1_addr [3];
    logic [15:0] s1_dat  [3];
    logic [0:8][7:0] s1;

    initial begin
        int base;
        int n;
        logic [7:0] ck, hi, lo;
        bit exp_we;

        s1 = {8'h00, 8'h03, 8'hF1, 8'h0A, 8'hF2, 8'h0A, 8'hD1, 8'h02, 8'hD3};
        s1_addr = '{16'h0000, 16'h0002, 16'h0004};
        s1_dat  = '{16'hF10A, 16'hF20A, 16'hD102};

        vecs[0] = '{name:"s1_good",  len:9,  b:{8'h00,8'h03,8'hF1,8'h0A,8'hF2,8'h0A,8'hD1,8'h02,8'hD3,8'h00}, exp_wr:3, exp_done:1, exp_err:0};
        vecs[1] = '{name:"s1_badck", len:10, b:{8'h00,8'h03,8'hF1,8'h0A,8'hF2,8'h0A,8'hD1,8'h02,8'hD2,8'h55}, exp_wr:3, exp_done:0, exp_err:1};
        vecs[2] = '{name:"n0_good",  len:3,  b:{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_wr:0, exp_done:1, exp_err:0};
        vecs[3] = '{name:"n0_bad",   len:3,  b:{8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_wr:0, exp_done:0, exp_err:1};
        vecs[4] = '{name:"n129",     len:4,  b:{8'h00,8'h81,8'h12,8'h34,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_wr:0, exp_done:0, exp_err:1};
        vecs[5] = '{name:"n256",     len:3,  b:{8'h01,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_wr:0, exp_done:0, exp_err:1};
        vecs[6] = '{name:"n1_good",  len:5,  b:{8'h00,8'h01,8'hAB,8'hCD,8'h67,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_wr:1, exp_done:1, exp_err:0};

        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        #12;
        chk("rst_mem_we",   32'(bif.mem_we),   0);
        chk("rst_mem_addr", 32'(bif.mem_addr), 0);
        chk("rst_mem_in",   32'(bif.mem_in),   0);
        chk("rst_cpu_run",  32'(cpu_run),      0);
        chk("rst_done",     32'(done),         0);
        chk("rst_error",    32'(error),        0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bif.in_ready), 1);

        for (int t = 0; t < 7; t++) begin
            do_reset();
            base = wr_total;
            n = int'({vecs[t].b[0], vecs[t].b[1]});
            for (int i = 0; i < vecs[t].len; i++) begin
                send_byte(vecs[t].b[i], 0);
                exp_we = (i >= 3) && (i % 2 == 1) && ((i - 1) / 2 <= n) && (n <= 128);
                chk({vecs[t].name, "_we"}, 32'(bif.mem_we), 32'(exp_we));
            end
            repeat (2) @(negedge clk);
            chk({vecs[t].name, "_writes"},   32'(wr_total - base),  32'(vecs[t].exp_wr));
            chk({vecs[t].name, "_done"},     32'(done),             32'(vecs[t].exp_done));
            chk({vecs[t].name, "_cpu_run"},  32'(cpu_run),          32'(vecs[t].exp_done));
            chk({vecs[t].name, "_error"},    32'(error),            32'(vecs[t].exp_err));
            chk({vecs[t].name, "_in_ready"}, 32'(bif.in_ready),     0);
            if (t == 0) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("s1_addr%0d", k), 32'(wr_addr[base + k]), 32'(s1_addr[k]));
                    chk($sformatf("s1_data%0d", k), 32'(wr_dat[base + k]),  32'(s1_dat[k]));
                    chk($sformatf("s1_mem%0d", k),  32'(mem[k]),            32'(s1_dat[k]));
                end
            end
        end

        // Full-depth program: 128 words, last write at 0x00FE.
        do_reset();
        base = wr_total;
        send_byte(8'h00, 0);
        send_byte(8'h80, 0);
        ck = 8'h80;
        for (int k = 0; k < 128; k++) begin
            hi = 8'(k) ^ 8'hC3;
            lo = 8'(k);
            ck = ck ^ hi ^ lo;
            send_byte(hi, 0);
            send_byte(lo, 0);
            if (k == 127) chk("full_last_we", 32'(bif.mem_we), 1);
        end
        send_byte(ck, 0);
        chk("full_done_next_cycle", 32'(done), 1);
        chk("full_writes", 32'(wr_total - base), 128);
        chk("full_last_addr", 32'(wr_addr[base + 127]), 32'h00FE);
        chk("full_mem0", 32'(mem[0]), 32'h00C3 << 8);
        chk("full_mem127", 32'(mem[127]), 32'hBC7F);
        chk("full_cpu_run", 32'(cpu_run), 1);

        // Stream 1 with random idle gaps between bytes.
        do_reset();
        base = wr_total;
        for (int i = 0; i < 9; i++) send_byte(s1[i], $urandom_range(0, 5));
        repeat (2) @(negedge clk);
        chk("gap_writes", 32'(wr_total - base), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gap_addr%0d", k), 32'(wr_addr[base + k]), 32'(s1_addr[k]));
            chk($sformatf("gap_data%0d", k), 32'(wr_dat[base + k]),  32'(s1_dat[k]));
        end
        chk("gap_done", 32'(done), 1);
        chk("gap_error", 32'(error), 0);

        // Reset just after the second DATA_LO transfer drops the pending write.
        do_reset();
        base = wr_total;
        for (int i = 0; i < 6; i++) send_byte(s1[i], 0);
        chk("abort_pending_we", 32'(bif.mem_we), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_we",       32'(bif.mem_we),   0);
        chk("abort_addr",     32'(bif.mem_addr), 0);
        chk("abort_data",     32'(bif.mem_in),   0);
        chk("abort_in_ready", 32'(bif.in_ready), 1);
        @(posedge clk);
        #1;
        chk("abort_writes", 32'(wr_total - base), 1);
        @(negedge clk);
        rst_n = 1'b1;
        base = wr_total;
        for (int i = 0; i < 9; i++) send_byte(s1[i], 0);
        repeat (2) @(negedge clk);
        chk("replay_writes", 32'(wr_total - base), 3);
        chk("replay_addr2",  32'(wr_addr[base + 2]), 32'h0004);
        chk("replay_done",   32'(done), 1);

        chk("no_back_to_back_we", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
